instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have these ports, one per line, with name, direction, width and meaning; clock and reset come first.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- power  in  1  run enable; the same signal that drives the program counter's power input.
- pc  in  8  current program counter value (the program counter's pc output).
- prog_we  in  1  program-load write enable.
- prog_addr  in  8  program-load address.
- prog_data  in  16  program-load data.
- zero_flag  in  1  condition flag from execute, used by BZ.
- instr_ready  in  1  downstream accepts instr this cycle.
- instr  out  16  fetched instruction word.
- instr_pc  out  8  address that instr was fetched from.
- instr_valid  out  1  instr/instr_pc hold a valid instruction.
- branch_en  out  1  to the program counter: load branch_pc at the next edge.
- branch_pc  out  8  to the program counter: branch target.
- stop_en  out  1  to the program counter: hold pc.
- halted  out  1  FSM is in HALT.
- fetch_count  out  16  number of instructions captured, saturating.

Function
REQ-002 Instruction word fields SHALL be: [15:12] opcode, [11:8] reserved, [7:0] imm.
REQ-003 Opcodes SHALL be: 0x0 NOP, 0x1 JMP, 0x2 BZ, 0xF HALT; all other opcodes are pass-through ALU ops.
REQ-004 Program memory SHALL be 256x16 with asynchronous read at pc and synchronous write on prog_we.
REQ-005 prog_we SHALL be honoured only when the state is not RUN; writes issued in RUN are ignored.
REQ-006 The FSM SHALL have states IDLE, RUN and HALT.
REQ-007 FSM transitions SHALL be: IDLE->RUN when power=1; RUN->IDLE when power=0; RUN->HALT on capture of a HALT opcode; HALT->IDLE when power=0.
REQ-008 stall SHALL be defined as instr_valid=1 and instr_ready=0.
REQ-009 A capture SHALL occur when state=RUN, power=1 and no stall: instr<=mem[pc], instr_pc<=pc, instr_valid<=1, fetch_count+1.
REQ-010 fetch_count SHALL saturate at 0xFFFF.
REQ-011 instr_valid SHALL clear when instr_valid=1, instr_ready=1 and no capture happens in the same cycle.
REQ-012 stop_en SHALL be combinational: 1 when state!=RUN, or power=0, or stall.
REQ-013 branch_en SHALL be combinational: 1 only in a capture cycle where mem[pc] is JMP, or is BZ with zero_flag=1.
REQ-014 branch_pc SHALL equal mem[pc][7:0] whenever branch_en=1, and 0x00 otherwise.
REQ-015 Branches SHALL take zero bubbles: the program counter loads the target at the same edge the branch word is captured, and the branch word is still forwarded.
REQ-016 A stall SHALL gate both branch_en and capture; instr is held stable until accepted.
REQ-017 On HALT capture, the HALT word SHALL be forwarded, and stop_en=1 from the next cycle.
REQ-018 pc SHALL wrap 0xFF->0x00 with no special handling in this block.
REQ-019 halted SHALL equal 1 exactly when state=HALT.

Reset
REQ-020 When rst_n=0, the block SHALL asynchronously set: state=IDLE, instr=0x0000, instr_pc=0x00, instr_valid=0, fetch_count=0.
REQ-021 While in reset, outputs SHALL be: branch_en=0, branch_pc=0x00, stop_en=1, halted=0.
REQ-022 Program memory SHALL NOT be reset; its contents survive rst_n and power cycling.
REQ-023 Reset asserted mid-RUN SHALL drop any pending instr_valid immediately.

Structure
REQ-024 Package fetch_pkg SHALL hold: the opcode enum (NOP, JMP, BZ, HALT), the state enum (IDLE, RUN, HALT), and constants PC_W=8, INSTR_W=16, MEM_DEPTH=256.
REQ-025 Sub-module instr_mem (256x16, async read, sync write) SHALL hold the program array; FSM, capture register and counter stay in instr_fetch.

Verification
REQ-026 Load 0x00=0x0000 and 0x01=0xF000, set power=1, instr_ready=1, pc=0x00 then 0x01 -> captures 0x0000@0x00 then 0xF000@0x01; then halted=1, stop_en=1, fetch_count=2.
REQ-027 mem[0x05]=0x1020 (JMP 0x20), in RUN with pc=0x05 -> in that cycle branch_en=1, branch_pc=0x20, stop_en=0; next cycle instr=0x1020, instr_pc=0x05.
REQ-028 mem[0x10]=0x2040 (BZ 0x40): with zero_flag=0 -> branch_en=0; with zero_flag=1 -> branch_en=1, branch_pc=0x40.
REQ-029 Capture at pc=0x03, hold instr_ready=0 for 3 cycles -> stop_en=1, instr and fetch_count unchanged, and a JMP at mem[pc] gives no branch_en; release instr_ready -> capture resumes next edge.
REQ-030 Attempt prog_we in RUN at addr 0x07 with data 0xAAAA -> mem[0x07] unchanged; drop power -> IDLE, write succeeds, readback via fetch at pc=0x07 = 0xAAAA.
REQ-031 Assert rst_n=0 mid-RUN with instr_valid=1 -> instr_valid=0, fetch_count=0, stop_en=1 immediately without a clock edge; program memory contents retained.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch stage: opcode and FSM
// state encodings plus the instruction-word field helpers.
package fetch_pkg;

  localparam int PC_W      = 8;
  localparam int INSTR_W   = 16;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_JMP  = 4'h1,
    OP_BZ   = 4'h2,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Word layout: [15:12] opcode, [11:8] reserved, [7:0] immediate.
  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[15:12];
  endfunction

  function automatic logic [PC_W-1:0] imm_of(input logic [INSTR_W-1:0] word);
    return word[PC_W-1:0];
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Program store: 256x16 array, combinational read port, clocked write port.
module instr_mem
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               we_i,
  input  logic [PC_W-1:0]    waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [PC_W-1:0]    raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [MEM_DEPTH];

  // NOTE: the array has no reset on purpose -- a loaded program must survive
  // rst_n and power cycling, and a reset port would also block RAM mapping.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE/RUN/HALT control, capture register with
// ready/valid hand-off, zero-bubble branch steering and a capture counter.
module instr_fetch
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               power,
  input  logic [PC_W-1:0]    pc,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               zero_flag,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic               branch_en,
  output logic [PC_W-1:0]    branch_pc,
  output logic               stop_en,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;
  logic [15:0]        count_q, count_d;

  logic [INSTR_W-1:0] word;
  logic [3:0]         op;
  logic               stall;
  logic               capture;
  logic               mem_we;

  // Program loading is locked out while the fetch loop is running.
  assign mem_we = prog_we && (state_q != ST_RUN);

  instr_mem u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc),
    .rdata_o (word)
  );

  assign op      = opcode_of(word);
  assign stall   = valid_q && !instr_ready;
  assign capture = (state_q == ST_RUN) && power && !stall;

  // Branch is resolved on the word being captured so the PC redirects at
  // the same edge; a stall suppresses it together with the capture.
  assign branch_en = capture && ((op == OP_JMP) || ((op == OP_BZ) && zero_flag));
  assign branch_pc = branch_en ? imm_of(word) : '0;
  assign stop_en   = (state_q != ST_RUN) || !power || stall;
  assign halted    = (state_q == ST_HALT);

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    count_d    = count_q;

    if (capture) begin
      instr_d    = word;
      instr_pc_d = pc;
      valid_d    = 1'b1;
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end else if (valid_q && instr_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: if (power) state_d = ST_RUN;
      ST_RUN: begin
        if (!power)                        state_d = ST_IDLE;
        else if (capture && op == OP_HALT) state_d = ST_HALT;
      end
      ST_HALT: if (!power) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// traffic, all compared against a behavioural model of the fetch rules.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        power = 1'b0;
  logic [7:0]  pc = '0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic        zero_flag = 1'b0;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        branch_en;
  logic [7:0]  branch_pc;
  logic        stop_en;
  logic        halted;
  logic [15:0] fetch_count;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .power       (power),
    .pc          (pc),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .zero_flag   (zero_flag),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .branch_en   (branch_en),
    .branch_pc   (branch_pc),
    .stop_en     (stop_en),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = halted.
  logic [15:0] m_mem [256];
  int          m_mode;
  logic [15:0] m_instr;
  logic [7:0]  m_ipc;
  logic        m_valid;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_instr = 16'h0000;
    m_ipc   = 8'h00;
    m_valid = 1'b0;
    m_cnt   = 0;
  endtask

  // Compare every DUT output against what the model says for current inputs.
  task automatic check_all(input string ph);
    logic [15:0] w;
    bit          stall, cap, br;
    w     = m_mem[pc];
    stall = m_valid && !instr_ready;
    cap   = (m_mode == 1) && power && !stall;
    br    = cap && ((w[15:12] == 4'h1) || ((w[15:12] == 4'h2) && zero_flag));
    check({ph, ".instr"},       instr,       m_instr);
    check({ph, ".instr_pc"},    instr_pc,    m_ipc);
    check({ph, ".instr_valid"}, instr_valid, m_valid);
    check({ph, ".fetch_count"}, fetch_count, m_cnt);
    check({ph, ".branch_en"},   branch_en,   br);
    check({ph, ".branch_pc"},   branch_pc,   br ? w[7:0] : 8'h00);
    check({ph, ".stop_en"},     stop_en,     (m_mode != 1) || !power || stall);
    check({ph, ".halted"},      halted,      m_mode == 2);
  endtask

  // One clock: check outputs for the present inputs, clock, update the model.
  task automatic step(input string ph);
    logic [15:0] w;
    bit          cap;
    #1;
    check_all(ph);
    w   = m_mem[pc];
    cap = (m_mode == 1) && power && !(m_valid && !instr_ready);
    @(posedge clk);
    if (prog_we && m_mode != 1) m_mem[prog_addr] = prog_data;
    if (cap) begin
      m_instr = w;
      m_ipc   = pc;
      m_valid = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_valid && instr_ready) begin
      m_valid = 1'b0;
    end
    case (m_mode)
      0: if (power) m_mode = 1;
      1: if (!power) m_mode = 0; else if (cap && w[15:12] == 4'hF) m_mode = 2;
      default: if (!power) m_mode = 0;
    endcase
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step("load");
    prog_we = 1'b0;
  endtask

  int saved_cnt;
  logic [15:0] saved_instr;

  initial begin
    model_reset();
    #12;
    check_all("reset");
    check("reset.stop_en_const", stop_en, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole program store so every pc has a defined word.
    for (int i = 0; i < 256; i++) load(8'(i), 16'($urandom));

    // HALT sequence: NOP at 0x00, HALT at 0x01.
    load(8'h00, 16'h0000);
    load(8'h01, 16'hF000);
    load(8'h03, 16'h1055);
    load(8'h05, 16'h1020);
    load(8'h07, 16'h3333);
    load(8'h10, 16'h2040);
    power = 1'b1; instr_ready = 1'b1; pc = 8'h00;
    step("r26.enter");
    step("r26.nop");
    check("r26.instr0", instr, 16'h0000);
    check("r26.pc0", instr_pc, 8'h00);
    pc = 8'h01;
    step("r26.halt");
    check("r26.instr1", instr, 16'hF000);
    check("r26.pc1", instr_pc, 8'h01);
    check("r26.halted", halted, 1'b1);
    check("r26.stop_en", stop_en, 1'b1);
    check("r26.count", fetch_count, 16'd2);
    power = 1'b0;
    step("r26.off");

    // JMP at 0x05.
    power = 1'b1; pc = 8'h05;
    step("r27.enter");
    #1;
    check("r27.branch_en", branch_en, 1'b1);
    check("r27.branch_pc", branch_pc, 8'h20);
    check("r27.stop_en", stop_en, 1'b0);
    step("r27.jmp");
    check("r27.instr", instr, 16'h1020);
    check("r27.instr_pc", instr_pc, 8'h05);

    // BZ at 0x10 with both flag values.
    pc = 8'h10; zero_flag = 1'b0;
    #1;
    check("r28.nz_branch_en", branch_en, 1'b0);
    step("r28.nz");
    zero_flag = 1'b1;
    #1;
    check("r28.z_branch_en", branch_en, 1'b1);
    check("r28.z_branch_pc", branch_pc, 8'h40);
    step("r28.z");
    zero_flag = 1'b0;

    // Stall with a JMP pending at mem[pc].
    pc = 8'h03;
    step("r29.cap");
    saved_cnt   = int'(fetch_count);
    saved_instr = instr;
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("r29.stall_stop", stop_en, 1'b1);
      check("r29.stall_br", branch_en, 1'b0);
      step("r29.stall");
      check("r29.hold_instr", instr, saved_instr);
      check("r29.hold_cnt", fetch_count, 16'(saved_cnt));
    end
    instr_ready = 1'b1;
    #1;
    check("r29.resume_br", branch_en, 1'b1);
    step("r29.resume");
    check("r29.resume_cnt", fetch_count, 16'(saved_cnt + 1));

    // Program write is ignored while running, accepted once idle.
    load(8'h07, 16'hAAAA);
    pc = 8'h07;
    step("r30.readrun");
    check("r30.unchanged", instr, 16'h3333);
    power = 1'b0;
    step("r30.off");
    load(8'h07, 16'hAAAA);
    power = 1'b1;
    step("r30.enter");
    step("r30.fetch");
    check("r30.readback", instr, 16'hAAAA);

    // Asynchronous reset mid-run with a valid instruction held.
    instr_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("r31.valid", instr_valid, 1'b0);
    check("r31.count", fetch_count, 16'd0);
    check("r31.stop_en", stop_en, 1'b1);
    check("r31.branch_en", branch_en, 1'b0);
    model_reset();
    check_all("r31");
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    step("r31.enter");
    step("r31.fetch");
    check("r31.retained", instr, 16'hAAAA);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      power       = ($urandom_range(0, 15) != 0);
      pc          = 8'($urandom);
      instr_ready = ($urandom_range(0, 3) != 0);
      zero_flag   = 1'($urandom);
      prog_we     = ($urandom_range(0, 7) == 0);
      prog_addr   = 8'($urandom);
      prog_data   = 16'($urandom);
      step("rand");
    end
    prog_we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
